axis_bus_arbiter: RTL
=====================

Name: axis_bus_arbiter

Overview:
- Gathering end of the 16-FIFO AXI-Stream bus; the counterpart of the tready demux.
- Round-robin arbitrates 16 upstream FIFO streams at packet granularity.
- Muxes the granted stream through a one-stage output register.
- Drives the 8-bit bus_sel code (128+n when FIFO n is granted, 0 when none) consumed by axis_bus_demux.

Parameters:
- DATA_W, 32, tdata width per channel.
- MAX_BEATS, 256, beat limit per packet before forced release; legal range 2..65535.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_tvalid  input  16  per-FIFO tvalid; bit n belongs to FIFO n.
- in_tlast  input  16  per-FIFO tlast.
- in_tdata  input  16*DATA_W  per-FIFO tdata; FIFO n occupies bits [n*DATA_W +: DATA_W].
- in_tready  output  16  per-FIFO tready; one-hot or zero.
- bus_sel  output  8  registered grant code: 128+n when FIFO n is granted, 0 when idle.
- axis_out_tvalid  output  1  registered output tvalid.
- axis_out_tdata  output  DATA_W  registered output tdata.
- axis_out_tlast  output  1  registered output tlast.
- axis_out_tready  input  1  downstream ready.
- pkt_err  output  1  one-cycle pulse on forced packet release.

Behaviour:
- Reset (async, rst=1), all cleared: state=IDLE; bus_sel=0; rr_ptr=0; beat_cnt=0; axis_out_tvalid=0; axis_out_tdata=0; axis_out_tlast=0; pkt_err=0.
- Reset mid-packet abandons the packet. The output register is cleared and the beat held there is lost.
- States are IDLE and BUSY.
- IDLE:
  - in_tready=0; bus_sel=0.
  - If any in_tvalid bit is set, grant n = first set bit searching upward from rr_ptr, wrapping 15->0.
  - Next cycle: state=BUSY, bus_sel=128+n, beat_cnt=0.
  - Arbitration costs exactly one cycle.
- BUSY, granted n:
  - slot_free = !axis_out_tvalid || axis_out_tready.
  - in_tready[n] = slot_free; all other in_tready bits = 0.
- Beat accept (in_tvalid[n] && in_tready[n]):
  - Next cycle: axis_out_tdata = in_tdata slice n; axis_out_tvalid=1; beat_cnt += 1.
  - axis_out_tlast = in_tlast[n] || (beat_cnt == MAX_BEATS-1).
- Output register:
  - When axis_out_tready=1 with no new beat accepted, axis_out_tvalid clears.
  - tdata and tlast hold until the next load.
  - Throughput is 1 beat/cycle when axis_out_tready stays high.
  - Input-to-output latency is 1 cycle.
- Release on a beat accepted with in_tlast[n]=1:
  - Next cycle: state=IDLE, bus_sel=0, rr_ptr=(n+1) mod 16 (15 wraps to 0).
  - The output register keeps draining independently.
- Forced release on the MAX_BEATS-th beat accepted without in_tlast:
  - Same transition as a normal release, with axis_out_tlast forced to 1.
  - pkt_err=1 for exactly one cycle, the cycle the beat appears on the output.
  - The FIFO's remaining beats form a new packet on a later grant.
- Grant is held for the whole packet: in_tvalid[n] dropping mid-packet does not release it, and other requesters wait.
- Requests in the release cycle are ignored. Arbitration happens only in IDLE, so there is a minimum one-cycle gap (bus_sel=0) between packets.
- bus_sel is never an out-of-range value; only 0 or 128..143.
- AXI rules:
  - axis_out_tvalid never drops without axis_out_tready.
  - tdata and tlast are stable while tvalid=1 and tready=0.

Test Plan:
- Single packet: FIFO 3 sends 4 beats (tlast on the 4th), axis_out_tready=1.
  - Required: bus_sel=131 for 4 cycles starting one cycle after the request, then 0.
  - Output beats match with 1-cycle latency; tlast on beat 4; rr_ptr=4.
- Round robin: FIFOs 0, 5 and 15 request continuously with 2-beat packets, starting from reset.
  - Required grant order: 0, 5, 15, 0, 5, wrapping 15->0.
- Backpressure: FIFO 7 sends 3 beats while axis_out_tready=0 for 5 cycles mid-packet.
  - Required: in_tready[7]=0 while the slot is full; output data stable; no beat lost or duplicated.
- Forced release: MAX_BEATS=4, FIFO 2 sends 6 beats with no tlast.
  - Required: beat 4 has axis_out_tlast=1 and pkt_err pulses once.
  - bus_sel returns to 0; beats 5-6 are delivered on the next grant of FIFO 2.
- Async reset: assert rst mid-packet from FIFO 9, between clock edges.
  - Required: bus_sel=0, axis_out_tvalid=0 and in_tready=0 immediately, before the next edge.
  - After release, the first grant searches from FIFO 0.
- Idle stall: FIFO 1 is granted, then in_tvalid[1] drops for 3 cycles while FIFO 4 requests.
  - Required: bus_sel stays 129 and FIFO 4 is not granted until FIFO 1's tlast beat is accepted.

Source files
------------

// File: rtl/axis_bus_arbiter.sv
// Purpose : round-robin packet arbiter gathering 16 AXI-Stream FIFOs onto one bus.
// Latency : 1 cycle arbitration (IDLE) and 1 cycle input-to-output through the output register.
// Backpr. : the granted FIFO sees tready only while the output slot is empty or draining.
//
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   in_tvalid/in_tlast/in_tdata    16 upstream streams, FIFO n at bit n / slice n
//   in_tready                      per-FIFO ready, one-hot or zero
//   bus_sel                        registered grant code, 128+n while FIFO n owns the bus, else 0
//   axis_out_*                     registered downstream stream
//   pkt_err                        one-cycle pulse when a packet is cut at MAX_BEATS
module axis_bus_arbiter #(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          in_tvalid,
    input  logic [15:0]          in_tlast,
    input  logic [16*DATA_W-1:0] in_tdata,
    output logic [15:0]          in_tready,
    output logic [7:0]           bus_sel,
    output logic                 axis_out_tvalid,
    output logic [DATA_W-1:0]    axis_out_tdata,
    output logic                 axis_out_tlast,
    input  logic                 axis_out_tready,
    output logic                 pkt_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Beat counter value on the final permitted beat of a packet.
    localparam logic [15:0] LAST_CNT = 16'(MAX_BEATS - 1);

    state_t              state_q, state_d;
    logic [3:0]          grant_q, grant_d;
    logic [3:0]          rr_ptr_q, rr_ptr_d;
    logic [15:0]         beat_cnt_q, beat_cnt_d;
    logic [7:0]          bus_sel_q;
    logic                out_vld_q;
    logic [DATA_W-1:0]   out_dat_q;
    logic                out_last_q;
    logic                pkt_err_q;

    logic                pick_vld;
    logic [3:0]          pick_idx;
    logic                slot_free;
    logic                accept;
    logic                cnt_limit;
    logic                beat_last;
    logic                forced;
    logic [DATA_W-1:0]   sel_dat;

    // Round-robin search: walk offsets from the top down so the smallest
    // offset from rr_ptr is the last (and therefore winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr_q;
        for (int k = 15; k >= 0; k--) begin
            if (in_tvalid[rr_ptr_q + 4'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_ptr_q + 4'(k);
            end
        end
    end

    assign slot_free = !out_vld_q || axis_out_tready;
    assign sel_dat   = in_tdata[int'(grant_q) * DATA_W +: DATA_W];
    assign accept    = (state_q == BUSY) && in_tvalid[grant_q] && slot_free;
    assign cnt_limit = (beat_cnt_q == LAST_CNT);
    assign beat_last = in_tlast[grant_q] || cnt_limit;
    // A packet reaching the limit with its own tlast is a normal release.
    assign forced    = accept && !in_tlast[grant_q] && cnt_limit;

    always_comb begin
        in_tready = 16'd0;
        if (state_q == BUSY && slot_free) begin
            in_tready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d    = BUSY;
                    grant_d    = pick_idx;
                    beat_cnt_d = 16'd0;
                end
            end
            BUSY: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (beat_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 4'd0;
            rr_ptr_q   <= 4'd0;
            beat_cnt_q <= 16'd0;
            bus_sel_q  <= 8'd0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            bus_sel_q  <= (state_d == BUSY) ? {4'b1000, grant_d} : 8'd0;
            pkt_err_q  <= forced;
            if (accept) begin
                out_vld_q  <= 1'b1;
                out_dat_q  <= sel_dat;
                out_last_q <= beat_last;
            end else if (axis_out_tready) begin
                out_vld_q  <= 1'b0;
            end
        end
    end

    assign bus_sel         = bus_sel_q;
    assign axis_out_tvalid = out_vld_q;
    assign axis_out_tdata  = out_dat_q;
    assign axis_out_tlast  = out_last_q;
    assign pkt_err         = pkt_err_q;

endmodule
